// File: rtl/v_mem_seq_if.sv
// Single-port data-memory handshake between the vector load/store sequencer
// and data memory.
interface v_mem_seq_if #(
    parameter int unsigned ELEN = 32
);
    logic            mem_req;
    logic            mem_we;
    logic [31:0]     mem_addr;
    logic [ELEN-1:0] mem_wdata;
    logic [ELEN-1:0] mem_rdata;
    logic            mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/v_mem_seq.sv
// Vector load/store sequencer: serialises the enabled lanes of one vector memory
// op onto a 32-bit memory handshake and assembles the 128-bit load result.
module v_mem_seq #(
    parameter int unsigned VLEN = 128,
    parameter int unsigned ELEN = 32,
    localparam int unsigned NL = VLEN / ELEN,
    localparam int unsigned IW = (NL > 1) ? $clog2(NL) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            is_store,
    input  logic [VLEN-1:0] addr,
    input  logic [VLEN-1:0] vs3_in,
    input  logic [NL-1:0]   vm,
    v_mem_seq_if.master     mem,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [VLEN-1:0] ld_data
);

    typedef enum logic [1:0] {
        StIdle,
        StLane,
        StDone,
        StErr
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   idx_q;
    logic            is_store_q;
    logic [VLEN-1:0] addr_q;
    logic [VLEN-1:0] vs3_q;
    logic [NL-1:0]   vm_q;
    logic [VLEN-1:0] ld_data_q;
    logic            done_q;
    logic            err_q;

    logic            misalign;
    logic            lane_en;
    logic            lane_last;

    always_comb begin
        misalign = 1'b0;
        for (int i = 0; i < int'(NL); i++) begin
            if (vm[i] && (addr[i*ELEN +: 2] != 2'b00)) begin
                misalign = 1'b1;
            end
        end
    end

    assign lane_en   = vm_q[idx_q];
    assign lane_last = (idx_q == IW'(NL - 1));

    // Request fields decode straight from captured registers, so they stay
    // stable across stalls and drop the instant reset clears the state.
    assign mem.mem_req   = (state_q == StLane) && lane_en;
    assign mem.mem_we    = mem.mem_req && is_store_q;
    assign mem.mem_addr  = addr_q[idx_q*ELEN +: 32];
    assign mem.mem_wdata = vs3_q[idx_q*ELEN +: ELEN];

    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign err     = err_q;
    assign ld_data = ld_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            is_store_q <= 1'b0;
            addr_q     <= '0;
            vs3_q      <= '0;
            vm_q       <= '0;
            ld_data_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        is_store_q <= is_store;
                        addr_q     <= addr;
                        vs3_q      <= vs3_in;
                        vm_q       <= vm;
                        ld_data_q  <= vs3_in;
                        idx_q      <= '0;
                        err_q      <= 1'b0;
                        state_q    <= misalign ? StErr : StLane;
                    end
                end
                StLane: begin
                    // Masked lanes burn one cycle; mem_ready is only honoured on a live request.
                    if (!lane_en || mem.mem_ready) begin
                        if (lane_en && !is_store_q) begin
                            ld_data_q[idx_q*ELEN +: ELEN] <= mem.mem_rdata;
                        end
                        if (lane_last) begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                StErr: begin
                    done_q  <= 1'b1;
                    err_q   <= 1'b1;
                    state_q <= StDone;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_v_mem_seq.sv
// Scoreboard bench for v_mem_seq: directed ops push expected requests and
// completions; a negedge monitor pops and compares them.
module tb_v_mem_seq;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         is_store = 1'b0;
    logic [127:0] addr = '0;
    logic [127:0] vs3_in = '0;
    logic [3:0]   vm = '0;
    logic         busy;
    logic         done;
    logic         err;
    logic [127:0] ld_data;

    v_mem_seq_if mif ();

    v_mem_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .is_store (is_store),
        .addr     (addr),
        .vs3_in   (vs3_in),
        .vm       (vm),
        .mem      (mif),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .ld_data  (ld_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        int           at;
        logic         err;
        logic [127:0] ld;
    } done_t;

    logic [64:0] req_q[$];
    done_t       done_q[$];

    // Memory model: rdata = 0xA0 + word index; optional stall on one address.
    logic [31:0] stall_addr = '0;
    int          stall_len = 0;
    int          epoch = 0;
    int          seen_epoch = 0;
    int          stall_seen = 0;

    always @(posedge clk) begin
        if (epoch != seen_epoch) begin
            seen_epoch <= epoch;
            stall_seen <= 0;
        end else if (mif.mem_req && !mif.mem_ready) begin
            stall_seen <= stall_seen + 1;
        end
    end

    assign mif.mem_ready = mif.mem_req && !((mif.mem_addr == stall_addr) && (stall_seen < stall_len));
    assign mif.mem_rdata = 32'hA0 + {2'b00, mif.mem_addr[31:2]};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    logic        held = 1'b0;
    logic [64:0] held_v;
    logic [64:0] mon_req;
    done_t       mon_done;

    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("req_stable", {mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_wdata},
                      {1'b1, held_v});
            end
            held = 1'b0;
            if (mif.mem_req) begin
                check("busy_in_req", busy, 1);
                if (mif.mem_ready) begin
                    if (req_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_req: we=%b addr=%h wdata=%h want none",
                                 mif.mem_we, mif.mem_addr, mif.mem_wdata);
                    end else begin
                        mon_req = req_q.pop_front();
                        check("req", {mif.mem_we, mif.mem_addr, mif.mem_wdata}, mon_req);
                    end
                end else begin
                    held   = 1'b1;
                    held_v = {mif.mem_we, mif.mem_addr, mif.mem_wdata};
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: at cycle %0d want no done", cyc);
                end else begin
                    mon_done = done_q.pop_front();
                    check("done_cycle", cyc, mon_done.at);
                    check("err", err, mon_done.err);
                    check("ld_data", ld_data, mon_done.ld);
                    check("busy_at_done", busy, 1);
                end
            end
        end
    end

    // Drives one op for a single cycle and pushes its expected traffic; lat=0 means no done.
    task automatic issue(input logic st, input logic [127:0] a, input logic [127:0] v,
                         input logic [3:0] m, input logic [31:0] sa, input int sl,
                         input int lat, input logic e_err, input logic [127:0] e_ld);
        @(posedge clk);
        #2;
        start      = 1'b1;
        is_store   = st;
        addr       = a;
        vs3_in     = v;
        vm         = m;
        stall_addr = sa;
        stall_len  = sl;
        epoch++;
        if (!e_err) begin
            for (int i = 0; i < 4; i++) begin
                if (m[i]) req_q.push_back({st, a[32*i +: 32], v[32*i +: 32]});
            end
        end
        if (lat > 0) done_q.push_back('{at: cyc + lat, err: e_err, ld: e_ld});
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((req_q.size() != 0 || done_q.size() != 0) && n < 60) begin
            @(posedge clk);
            n++;
        end
        if (n >= 60) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: pending req=%0d done=%0d want 0", name, req_q.size(),
                     done_q.size());
            req_q.delete();
            done_q.delete();
        end
        @(posedge clk);
        #2;
        check({name, "_idle_busy"}, busy, 0);
    endtask

    localparam logic [127:0] A0  = 128'h0000000C_00000008_00000004_00000000;
    localparam logic [127:0] LD1 = 128'h000000A3_000000A2_000000A1_000000A0;
    localparam logic [127:0] V   = 128'h33333333_22222222_11111111_00000000;

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check("rst_mem_req", mif.mem_req, 0);
        check("rst_busy", busy, 0);
        check("rst_done_err", {done, err}, 0);
        check("rst_ld_data", ld_data, 0);
        rst = 1'b0;
        @(posedge clk);
        #2;
        check("idle_busy", busy, 0);

        // Full load, addresses 0,4,8,C.
        issue(1'b0, A0, V, 4'b1111, 32'h0, 0, 5, 1'b0, LD1);
        wait_idle("t1");

        // Store, lanes 0 and 2 only; ld_data keeps vs3.
        issue(1'b1, 128'h0000001C_00000018_00000014_00000010,
              128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0, 4'b0101, 32'h0, 0, 5, 1'b0,
              128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0);
        wait_idle("t2");

        // Load lane 1 only; others keep 0xFFFFFFFF.
        issue(1'b0, 128'h0000002C_00000028_00000024_00000020, {128{1'b1}}, 4'b0010,
              32'h0, 0, 5, 1'b0, 128'hFFFFFFFF_FFFFFFFF_000000A9_FFFFFFFF);
        wait_idle("t3");

        // All lanes masked: no requests, done still at T+5.
        issue(1'b0, A0, V, 4'b0000, 32'h0, 0, 5, 1'b0, V);
        wait_idle("vm0");

        // Three-cycle stall on lane 1.
        issue(1'b0, A0, V, 4'b1111, 32'h4, 3, 8, 1'b0, LD1);
        wait_idle("t4");

        // Misaligned enabled lane.
        issue(1'b0, 128'h0000000C_00000008_00000004_00000006, V, 4'b0001, 32'h0, 0, 2,
              1'b1, V);
        wait_idle("t5a");

        // Same misaligned address on a masked lane.
        issue(1'b0, 128'h0000003C_00000038_00000006_00000030, V, 4'b1101, 32'h0, 0, 5,
              1'b0, 128'h000000AF_000000AE_11111111_000000AC);
        wait_idle("t5b");

        // Start while busy must launch nothing.
        issue(1'b0, A0, V, 4'b1111, 32'h0, 0, 5, 1'b0, LD1);
        @(posedge clk);
        #2;
        start    = 1'b1;
        is_store = 1'b1;
        addr     = 128'h0000004C_00000048_00000044_00000040;
        vm       = 4'b1111;
        @(posedge clk);
        #2;
        start = 1'b0;
        wait_idle("busy_start");
        repeat (8) @(posedge clk);

        // Reset while lane 2 is stalled.
        issue(1'b0, A0, V, 4'b1111, 32'h8, 20, 0, 1'b0, '0);
        begin
            int n = 0;
            while (!(mif.mem_req && mif.mem_addr == 32'h8) && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (n >= 20) begin
                total++;
                bad++;
                $display("FAIL rst_wait_lane2: lane 2 request not seen, want it within 20 cycles");
            end
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_mem_req", mif.mem_req, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ld_data", ld_data, 0);
        check("midrst_pending", req_q.size(), 2);
        req_q.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check("post_rst_busy", busy, 0);
        check("post_rst_done", done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
